// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, NOP encoding and writeback request type
package regfile_pkg;

    localparam int N  = 32;
    localparam int AW = 2;

    // Write-address encoding with the top bit set means "no write this cycle".
    localparam logic [AW:0] REG_NOP = {1'b1, {AW{1'b0}}};

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [N-1:0]  data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// rtl/regfile_wb_queue_if.sv - writeback request handshake (execute -> queue)
//   in_valid/in_addr/in_data driven by the execute side, in_ready by the queue.
interface regfile_wb_queue_if;
    import regfile_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [N-1:0]  in_data;

    modport master (output in_valid, output in_addr, output in_data, input in_ready);
    modport slave  (input in_valid, input in_addr, input in_data, output in_ready);
endinterface

// File: rtl/regfile_wb_queue_fifo.sv
// rtl/regfile_wb_queue_fifo.sv - DEPTH-entry writeback request FIFO (module wb_fifo)
//   push_i/push_req_i : enqueue one request
//   pop_i             : dequeue the head (entries_o[0])
//   entries_o/valid_o : contents in age order, index 0 = oldest
//   count_o           : occupied entries
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  wb_req_t                  push_req_i,
    input  logic                     pop_i,
    output wb_req_t                  entries_o [DEPTH],
    output logic [DEPTH-1:0]         valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_req_t         mem [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    // Storage is not reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push_i) mem[wr_ptr_q] <= push_req_i;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_i && !pop_i)      count_d = count_q + CW'(1);
        else if (!push_i && pop_i) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Present entries rotated so index 0 is the head; pointer arithmetic wraps mod DEPTH.
    for (genvar k = 0; k < DEPTH; k++) begin : g_view
        assign entries_o[k] = mem[rd_ptr_q + PW'(k)];
        assign valid_o[k]   = CW'(k) < count_q;
    end

    assign count_o = count_q;
endmodule

// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - writeback queue and drain stage for the register file write port
//   clk, rst_n          : clock, async active-low reset
//   bus (slave)         : in_valid/in_ready/in_addr/in_data request handshake
//   wr_hold             : stall the drain
//   w1, w               : registered write addr (REG_NOP = no write) and data
//   r1, r2              : read addresses searched for pending writes
//   fwd1_*, fwd2_*      : forwarding hit/value for r1, r2
//   count               : queued entries, excluding the output stage
//   Optional: REGFILE_FWD_EN enables the forwarding search.
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    regfile_wb_queue_if.slave       bus,
    input  logic                    wr_hold,
    output logic [AW:0]             w1,
    output logic [N-1:0]            w,
    input  logic [AW-1:0]           r1,
    input  logic [AW-1:0]           r2,
    output logic                    fwd1_hit,
    output logic [N-1:0]            fwd1_val,
    output logic                    fwd2_hit,
    output logic [N-1:0]            fwd2_val,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int CW = $clog2(DEPTH) + 1;

    wb_req_t          entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [CW-1:0]    count_w;
    logic             push, pop;
    logic [AW:0]      w1_q, w1_d;
    logic [N-1:0]     w_q, w_d;

    // Full blocks the push even when a pop happens in the same cycle.
    assign bus.in_ready = (count_w != CW'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = !wr_hold && (count_w != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_req_i ('{addr: bus.in_addr, data: bus.in_data}),
        .pop_i      (pop),
        .entries_o  (entries),
        .valid_o    (valid),
        .count_o    (count_w)
    );

    always_comb begin
        w1_d = REG_NOP;
        w_d  = '0;
        if (pop) begin
            w1_d = {1'b0, entries[0].addr};
            w_d  = entries[0].data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w1_q <= REG_NOP;
            w_q  <= '0;
        end else begin
            w1_q <= w1_d;
            w_q  <= w_d;
        end
    end

    assign w1    = w1_q;
    assign w     = w_q;
    assign count = count_w;

`ifdef REGFILE_FWD_EN
    // Output stage is the oldest pending write; queue entries are scanned
    // oldest to newest so the last match is the newest value.
    always_comb begin
        fwd1_hit = 1'b0;
        fwd1_val = '0;
        fwd2_hit = 1'b0;
        fwd2_val = '0;
        if (!w1_q[AW] && w1_q[AW-1:0] == r1) begin
            fwd1_hit = 1'b1;
            fwd1_val = w_q;
        end
        if (!w1_q[AW] && w1_q[AW-1:0] == r2) begin
            fwd2_hit = 1'b1;
            fwd2_val = w_q;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (valid[k] && entries[k].addr == r1) begin
                fwd1_hit = 1'b1;
                fwd1_val = entries[k].data;
            end
            if (valid[k] && entries[k].addr == r2) begin
                fwd2_hit = 1'b1;
                fwd2_val = entries[k].data;
            end
        end
    end
`else
    assign fwd1_hit = 1'b0;
    assign fwd1_val = '0;
    assign fwd2_hit = 1'b0;
    assign fwd2_val = '0;

    logic unused_fwd;
    always_comb begin
        unused_fwd = ^{r1, r2, valid};
        for (int k = 1; k < DEPTH; k++) unused_fwd = unused_fwd ^ (^entries[k]);
    end
`endif
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb/tb_regfile_wb_queue.sv - directed self-checking bench for regfile_wb_queue
module tb_regfile_wb_queue;
    import regfile_pkg::*;

    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wr_hold;
    logic [AW:0]     w1;
    logic [N-1:0]    w;
    logic [AW-1:0]   r1, r2;
    logic            fwd1_hit, fwd2_hit;
    logic [N-1:0]    fwd1_val, fwd2_val;
    logic [2:0]      count;

    int n_cmp = 0;
    int n_err = 0;

    regfile_wb_queue_if bus ();

    regfile_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .wr_hold  (wr_hold),
        .w1       (w1),
        .w        (w),
        .r1       (r1),
        .r2       (r2),
        .fwd1_hit (fwd1_hit),
        .fwd1_val (fwd1_val),
        .fwd2_hit (fwd2_hit),
        .fwd2_val (fwd2_val),
        .count    (count)
    );

    always #5 clk = ~clk;

`ifdef REGFILE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic [N-1:0] d);
        bus.in_valid = v;
        bus.in_addr  = a;
        bus.in_data  = d;
    endtask

    // Expected forwarding result: the real value when forwarding is built in, else 0.
    function automatic logic [N-1:0] fv(input logic [N-1:0] v);
        return FWD ? v : '0;
    endfunction

    initial begin
        rst_n   = 1'b0;
        wr_hold = 1'b0;
        r1      = '0;
        r2      = '0;
        drive(1'b0, '0, '0);

        // Reset
        step();
        step();
        check("rst_w1", w1, 3'b100);
        check("rst_w", w, 0);
        check("rst_ready", bus.in_ready, 1);
        check("rst_count", count, 0);
        check("rst_fwd1", fwd1_hit, 0);
        check("rst_fwd1v", fwd1_val, 0);
        rst_n = 1'b1;
        step();

        // Single write
        r1 = 2'd2;
        drive(1'b1, 2'd2, 32'h7);
        step();
        drive(1'b0, '0, '0);
        check("sw_count_k", count, 1);
        check("sw_w1_k", w1, 3'b100);
        check("sw_fwd_hit", fwd1_hit, FWD);
        check("sw_fwd_val", fwd1_val, fv(32'h7));
        step();
        check("sw_w1_k1", w1, 3'b010);
        check("sw_w_k1", w, 32'h7);
        check("sw_count_k1", count, 0);
        step();
        check("sw_w1_k2", w1, 3'b100);
        check("sw_w_k2", w, 0);

        // Full / backpressure
        wr_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 32'h10 + 32'(i));
            step();
        end
        check("full_count", count, 4);
        check("full_ready", bus.in_ready, 0);
        drive(1'b1, 2'd0, 32'h99);
        step();
        drive(1'b0, '0, '0);
        check("drop_count", count, 4);
        check("drop_w1", w1, 3'b100);
        r1 = 2'd0;
        r2 = 2'd3;
        #1;
        check("full_fwd1_hit", fwd1_hit, FWD);
        check("full_fwd1_val", fwd1_val, fv(32'h10));
        check("full_fwd2_hit", fwd2_hit, FWD);
        check("full_fwd2_val", fwd2_val, fv(32'h13));
        wr_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("drain%0d_w1", i), w1, {1'b0, 2'(i)});
            check($sformatf("drain%0d_w", i), w, 32'h10 + 32'(i));
            check($sformatf("drain%0d_cnt", i), count, 3'(3 - i));
        end
        step();
        check("drain_end_w1", w1, 3'b100);

        // Ordering: same register twice
        r1 = 2'd1;
        drive(1'b1, 2'd1, 32'hA);
        step();
        check("ord_a_fwd", fwd1_val, fv(32'hA));
        drive(1'b1, 2'd1, 32'hB);
        step();
        drive(1'b0, '0, '0);
        check("ord_w1_a", w1, 3'b001);
        check("ord_w_a", w, 32'hA);
        check("ord_both_hit", fwd1_hit, FWD);
        check("ord_both_val", fwd1_val, fv(32'hB));
        step();
        check("ord_w1_b", w1, 3'b001);
        check("ord_w_b", w, 32'hB);
        check("ord_stage_val", fwd1_val, fv(32'hB));
        step();
        check("ord_end_w1", w1, 3'b100);
        check("ord_end_hit", fwd1_hit, 0);

        // Reset mid-drain
        wr_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'(i + 1), 32'h20 + 32'(i));
            step();
        end
        drive(1'b0, '0, '0);
        check("md_count", count, 3);
        wr_hold = 1'b0;
        step();
        check("md_w1_first", w1, 3'b001);
        check("md_count2", count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("md_rst_w1", w1, 3'b100);
        check("md_rst_count", count, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("md_post%0d_w1", i), w1, 3'b100);
            check($sformatf("md_post%0d_cnt", i), count, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
